// File: rtl/pool1_serializer_if.sv
// pool1_serializer_if: bundles the pool1 capture port and the row-stream
// handshake of pool1_serializer.
//   master : the serializer (captures i_fmaps, drives the row stream)
//   slave  : its environment (pool1 on the load side, next layer on the stream side)
// Optional: POOL1_SER_PARITY_EN adds the o_par even-parity bit to the stream.
interface pool1_serializer_if #(
   parameter int CHANNELS = 18,
   parameter int DIM      = 12
);
   logic                          i_load;
   logic [0:CHANNELS*DIM*DIM-1]   i_fmaps;
   logic                          o_busy;
   logic                          o_valid;
   logic                          i_ready;
   logic [0:DIM-1]                o_data;
   logic [$clog2(CHANNELS)-1:0]   o_chan;
   logic [$clog2(DIM)-1:0]        o_row;
   logic                          o_last;
   logic                          o_done;
`ifdef POOL1_SER_PARITY_EN
   logic                          o_par;
`endif

   modport master (
      input  i_load, i_fmaps, i_ready,
      output o_busy, o_valid, o_data, o_chan, o_row, o_last, o_done
`ifdef POOL1_SER_PARITY_EN
      , output o_par
`endif
   );

   modport slave (
      output i_load, i_fmaps, i_ready,
      input  o_busy, o_valid, o_data, o_chan, o_row, o_last, o_done
`ifdef POOL1_SER_PARITY_EN
      , input o_par
`endif
   );
endinterface

// File: rtl/pool1_serializer.sv
// pool1_serializer: captures the flat CHANNELS x DIM x DIM pooled map vector
// in one cycle, then streams it one DIM-bit row per beat over valid/ready,
// channel-major, row-minor. o_data/o_chan/o_row/o_last are registered, so
// o_valid never depends on i_ready and everything holds under backpressure.
// Optional: define POOL1_SER_PARITY_EN for the o_par even-parity output.
module pool1_serializer #(
   parameter int CHANNELS = 18,
   parameter int DIM      = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   pool1_serializer_if.master bus
);
   localparam int N_BITS  = CHANNELS * DIM * DIM;
   localparam int N_BEATS = CHANNELS * DIM;
   localparam int CW      = $clog2(CHANNELS);
   localparam int RW      = $clog2(DIM);
   localparam int AW      = $clog2(N_BITS + DIM);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]        state_q;
   logic [0:N_BITS-1] buf_q;
   logic [0:DIM-1]    data_q;
   logic [CW-1:0]     chan_q;
   logic [RW-1:0]     row_q;
   logic [AW-1:0]     base_q;
   logic              last_q;
   logic              done_q;

   logic              load_acc;
   logic              fire;
   logic              advance;
   logic              row_wrap;
   logic [AW-1:0]     base_nxt;
   logic [AW-1:0]     sel;
   logic [CW-1:0]     chan_nxt;
   logic [RW-1:0]     row_nxt;
   logic              last_nxt;
   logic [0:DIM-1]    data_nxt;

   // Handshake decode and the coordinates/contents of the beat after the current one.
   always_comb begin
      // NOTE: every signal written here gets a value on every path, so no latch is inferred.
      load_acc = (state_q == IDLE) && bus.i_load;
      fire     = (state_q == SEND) && bus.i_ready;
      advance  = fire && !last_q;
      base_nxt = base_q + AW'(DIM);
      row_wrap = (row_q == RW'(DIM - 1));
      row_nxt  = row_wrap ? '0 : row_q + RW'(1);
      chan_nxt = row_wrap ? chan_q + CW'(1) : chan_q;
      last_nxt = (chan_nxt == CW'(CHANNELS - 1)) && (row_nxt == RW'(DIM - 1));
      // On the last beat base_nxt runs past the vector; point at row 0 instead.
      sel      = last_q ? '0 : base_nxt;
      data_nxt = buf_q[sel +: DIM];
   end

   // Capture buffer: loaded once per accepted load, read-only for the rest of the stream.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the buffer is deliberately reset so no stale map can leak out after a reset.
      if (!rst_n) begin
         buf_q <= '0;
      end else if (load_acc) begin
         buf_q <= bus.i_fmaps;
      end
   end

   // IDLE/SEND sequencing, beat counters and the registered output beat.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         chan_q  <= '0;
         row_q   <= '0;
         base_q  <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load_acc) begin
                  state_q <= SEND;
                  data_q  <= bus.i_fmaps[0 +: DIM];
                  chan_q  <= '0;
                  row_q   <= '0;
                  base_q  <= '0;
                  last_q  <= (N_BEATS == 1);
               end
            end
            SEND: begin
               if (fire) begin
                  if (last_q) begin
                     state_q <= IDLE;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     data_q  <= data_nxt;
                     chan_q  <= chan_nxt;
                     row_q   <= row_nxt;
                     base_q  <= base_nxt;
                     last_q  <= last_nxt;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.o_busy  = (state_q == SEND);
   assign bus.o_valid = (state_q == SEND);
   assign bus.o_data  = data_q;
   assign bus.o_chan  = chan_q;
   assign bus.o_row   = row_q;
   assign bus.o_last  = last_q;
   assign bus.o_done  = done_q;

`ifdef POOL1_SER_PARITY_EN
   logic par_q;

   // Parity follows data_q exactly: same load, same advance, held while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else if (load_acc) begin
         par_q <= ^bus.i_fmaps[0 +: DIM];
      end else if (advance) begin
         par_q <= ^data_nxt;
      end
   end

   assign bus.o_par = par_q;
`endif

endmodule

// File: tb/tb_pool1_serializer.sv
// tb_pool1_serializer: directed bench for pool1_serializer. Stimulus pushes the
// expected beats of every load into a scoreboard queue; a negedge monitor pops
// and compares on each handshake and checks stability during stalls.
// Optional: define POOL1_SER_PARITY_EN to also check o_par.
module tb_pool1_serializer;
   localparam int CHANNELS = 18;
   localparam int DIM      = 12;
   localparam int N_BITS   = CHANNELS * DIM * DIM;
   localparam int N_BEATS  = CHANNELS * DIM;
   localparam int CW       = $clog2(CHANNELS);
   localparam int RW       = $clog2(DIM);

   typedef struct packed {
      logic [0:DIM-1] data;
      logic [CW-1:0]  chan;
      logic [RW-1:0]  row;
      logic           last;
      logic           par;
   } beat_t;

   logic clk;
   logic rst_n;

   pool1_serializer_if #(.CHANNELS(CHANNELS), .DIM(DIM)) bus ();

   pool1_serializer #(.CHANNELS(CHANNELS), .DIM(DIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int    checks     = 0;
   int    failures   = 0;
   int    hs_count   = 0;
   int    done_count = 0;
   int    cyc        = 0;
   int    done_cyc[$];
   beat_t exp_q[$];
   bit    ready_rand  = 1'b0;
   bit    ready_level = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Downstream ready: fixed level or random, changed just after each rising edge.
   initial begin
      bus.i_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.i_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_level;
      end
   end

   // Monitor: scoreboard compare on handshakes, stability during stalls, done pulses.
   initial begin
      beat_t got;
      beat_t held;
      beat_t e;
      bit    stalled;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
            continue;
         end
         got.data = bus.o_data;
         got.chan = bus.o_chan;
         got.row  = bus.o_row;
         got.last = bus.o_last;
`ifdef POOL1_SER_PARITY_EN
         got.par  = bus.o_par;
`else
         got.par  = 1'b0;
`endif
         if (stalled && bus.o_valid) begin
            check("stall_data", got.data, held.data);
            check("stall_chan", got.chan, held.chan);
            check("stall_row",  got.row,  held.row);
            check("stall_last", got.last, held.last);
         end
         if (bus.o_valid && bus.i_ready) begin
            hs_count++;
            check("beat_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("beat_data", got.data, e.data);
               check("beat_chan", got.chan, e.chan);
               check("beat_row",  got.row,  e.row);
               check("beat_last", got.last, e.last);
`ifdef POOL1_SER_PARITY_EN
               check("beat_par",  got.par,  e.par);
`endif
            end
         end
         stalled = bus.o_valid && !bus.i_ready;
         held    = got;
         if (bus.o_done) begin
            done_count++;
            done_cyc.push_back(cyc);
            check("valid_low_at_done", bus.o_valid, 0);
         end
      end
   end

   // Expected beats straight from the bit-layout definition c*DIM*DIM + r*DIM + k.
   task automatic push_transfer(input logic [0:N_BITS-1] v);
      beat_t b;
      for (int c = 0; c < CHANNELS; c++) begin
         for (int r = 0; r < DIM; r++) begin
            for (int k = 0; k < DIM; k++) b.data[k] = v[c*DIM*DIM + r*DIM + k];
            b.chan = CW'(c);
            b.row  = RW'(r);
            b.last = (c == CHANNELS - 1) && (r == DIM - 1);
            b.par  = ^b.data;
            exp_q.push_back(b);
         end
      end
   endtask

   // Called just after a rising edge; returns just after the capturing edge.
   task automatic do_load(input logic [0:N_BITS-1] v);
      push_transfer(v);
      bus.i_fmaps = v;
      bus.i_load  = 1'b1;
      @(posedge clk);
      #1;
      bus.i_load  = 1'b0;
   endtask

   task automatic wait_done(input string name, input int prev, input int budget);
      int n;
      n = 0;
      while (done_count == prev && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(name, done_count, prev + 1);
   endtask

   logic [0:N_BITS-1] v1, v2, v3, vp;
   int d0, h0, n0;

   initial begin
      v1 = '0;
      v1[0] = 1'b1;
      v1[N_BITS-1] = 1'b1;
      for (int c = 0; c < CHANNELS; c++)
         for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++) begin
               v2[c*DIM*DIM + r*DIM + k] = ((c + r + k) % 2) == 1;
               v3[c*DIM*DIM + r*DIM + k] = ((c*7 + r*3 + k*5) % 3) == 0;
            end
      vp = '0;
      vp[0 +: DIM] = '1;
      vp[DIM + 0] = 1'b1;
      vp[DIM + 1] = 1'b1;
      vp[DIM + 2] = 1'b1;

      // Reset values appear asynchronously, before any clock edge.
      rst_n       = 1'b1;
      bus.i_load  = 1'b0;
      bus.i_fmaps = '0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", bus.o_valid, 0);
      check("rst_busy",  bus.o_busy,  0);
      check("rst_last",  bus.o_last,  0);
      check("rst_done",  bus.o_done,  0);
      check("rst_data",  bus.o_data,  0);
      check("rst_chan",  bus.o_chan,  0);
      check("rst_row",   bus.o_row,   0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ready_level = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_valid", bus.o_valid, 0);

      // Corner bits: first and last bit of the vector, continuous ready.
      d0 = done_count;
      h0 = hs_count;
      do_load(v1);
      check("t1_first_valid", bus.o_valid, 1);
      check("t1_first_busy",  bus.o_busy,  1);
      check("t1_first_data",  bus.o_data,  12'b1000_0000_0000);
      check("t1_first_chan",  bus.o_chan,  0);
      check("t1_first_row",   bus.o_row,   0);
      check("t1_first_last",  bus.o_last,  0);
      wait_done("t1_done", d0, 400);
      check("t1_handshakes", hs_count - h0, N_BEATS);
      check("t1_busy_after", bus.o_busy, 0);
      repeat (5) @(posedge clk);
      #1;
      check("t1_done_once", done_count, d0 + 1);

      // Checkerboard pattern under random backpressure.
      ready_rand = 1'b1;
      d0 = done_count;
      h0 = hs_count;
      do_load(v2);
      wait_done("t2_done", d0, 2000);
      check("t2_handshakes", hs_count - h0, N_BEATS);
      check("t2_queue_empty", exp_q.size(), 0);
      ready_rand = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Loads during the stream (beat 5 and the last-beat handshake) are ignored.
      d0 = done_count;
      h0 = hs_count;
      do_load(v3);
      bus.i_fmaps = ~v3;
      repeat (5) @(posedge clk);
      #1;
      bus.i_load = 1'b1;
      @(posedge clk);
      #1;
      bus.i_load = 1'b0;
      repeat (209) @(posedge clk);
      #1;
      check("t3_last_presented", bus.o_last, 1);
      bus.i_load = 1'b1;
      @(posedge clk);
      #1;
      bus.i_load = 1'b0;
      wait_done("t3_done", d0, 50);
      check("t3_handshakes", hs_count - h0, N_BEATS);
      repeat (5) @(posedge clk);
      #1;
      check("t3_no_restart", bus.o_valid, 0);
      check("t3_done_once", done_count, d0 + 1);

      // Asynchronous reset in the middle of the stream.
      d0 = done_count;
      h0 = hs_count;
      do_load(v3);
      repeat (100) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("t4_rst_valid", bus.o_valid, 0);
      check("t4_rst_busy",  bus.o_busy,  0);
      check("t4_rst_data",  bus.o_data,  0);
      check("t4_rst_chan",  bus.o_chan,  0);
      check("t4_rst_row",   bus.o_row,   0);
      check("t4_hs_before_rst", hs_count - h0, 100);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t4_no_done", done_count, d0);
      check("t4_idle_valid", bus.o_valid, 0);
      h0 = hs_count;
      do_load(v2);
      check("t4_new_chan", bus.o_chan, 0);
      check("t4_new_row",  bus.o_row,  0);
      check("t4_new_data", bus.o_data, 12'h555);
      wait_done("t4_done", d0, 400);
      check("t4_handshakes", hs_count - h0, N_BEATS);

      // Load held high: second capture in the o_done cycle, back-to-back transfers.
      repeat (2) @(posedge clk);
      #1;
      d0 = done_count;
      n0 = done_cyc.size();
      push_transfer(v1);
      push_transfer(v1);
      bus.i_fmaps = v1;
      bus.i_load  = 1'b1;
      @(posedge clk);
      #1;
      wait_done("t5_done1", d0, 400);
      check("t5_second_valid", bus.o_valid, 1);
      check("t5_second_chan",  bus.o_chan,  0);
      check("t5_second_row",   bus.o_row,   0);
      repeat (10) @(posedge clk);
      #1;
      bus.i_load = 1'b0;
      wait_done("t5_done2", d0 + 1, 400);
      if (done_cyc.size() >= n0 + 2)
         check("t5_done_spacing", done_cyc[n0 + 1] - done_cyc[n0], 217);
      else
         check("t5_done_pulses", done_cyc.size() - n0, 2);
      repeat (5) @(posedge clk);
      #1;
      check("t5_no_third", done_count, d0 + 2);

`ifdef POOL1_SER_PARITY_EN
      // Parity: all-ones row then a three-ones row.
      d0 = done_count;
      do_load(vp);
      check("par_row0", bus.o_par, 0);
      @(posedge clk);
      #1;
      check("par_row1", bus.o_par, 1);
      wait_done("par_done", d0, 400);
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
